// File: rtl/rv_div_seq_pkg.sv
// rtl/rv_div_seq_pkg.sv - shared state type, funct3 codes and decode helpers for the sequential divider
package rv_div_seq_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_CALC,
        DIV_FIX,
        DIV_DONE
    } div_state_t;

    localparam logic [2:0] DIV_F3_DIV  = 3'b100;
    localparam logic [2:0] DIV_F3_DIVU = 3'b101;
    localparam logic [2:0] DIV_F3_REM  = 3'b110;
    localparam logic [2:0] DIV_F3_REMU = 3'b111;

    function automatic logic div_is_signed(input logic [2:0] f3);
        return (f3 == DIV_F3_DIV) || (f3 == DIV_F3_REM);
    endfunction

    function automatic logic div_is_rem(input logic [2:0] f3);
        return (f3 == DIV_F3_REM) || (f3 == DIV_F3_REMU);
    endfunction

endpackage

// File: rtl/rv_div_seq_if.sv
// rtl/rv_div_seq_if.sv - request/control/result bundle between the ALU stage and the divider
interface rv_div_seq_if #(
    parameter int WIDTH = 32
);
    logic             i_flush;
    logic             i_stall;
    logic             i_start;
    logic [2:0]       i_funct3;
    logic [WIDTH-1:0] i_dividend;
    logic [WIDTH-1:0] i_divisor;
    logic             o_busy;
    logic             o_valid;
    logic [WIDTH-1:0] o_result;

    modport master (
        output i_flush, i_stall, i_start, i_funct3, i_dividend, i_divisor,
        input  o_busy, o_valid, o_result
    );

    modport slave (
        input  i_flush, i_stall, i_start, i_funct3, i_dividend, i_divisor,
        output o_busy, o_valid, o_result
    );
endinterface

// File: rtl/rv_div_step.sv
// rtl/rv_div_step.sv - one combinational restoring-division step (shift, trial subtract, select)
module rv_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH:0]   o_rem,
    output logic [WIDTH-1:0] o_quo
);
    logic [WIDTH+1:0] w_sh;
    logic [WIDTH+1:0] w_sub;
    logic             w_ge;

    // One extra headroom bit so the borrow of the trial subtract is the sign bit.
    assign w_sh  = {i_rem, i_quo[WIDTH-1]};
    assign w_sub = w_sh - {2'b00, i_div};
    assign w_ge  = ~w_sub[WIDTH+1];

    assign o_rem = w_ge ? w_sub[WIDTH:0] : w_sh[WIDTH:0];
    assign o_quo = {i_quo[WIDTH-2:0], w_ge};
endmodule

// File: rtl/rv_div_seq.sv
// rtl/rv_div_seq.sv - RV32M DIV/DIVU/REM/REMU sequencer, one quotient bit per cycle; RV_DIV_FAST_ZERO_EN short-circuits divide by zero
module rv_div_seq
    import rv_div_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic       i_clk,
    input  logic       i_reset,
    rv_div_seq_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    div_state_t       r_state;
    div_state_t       w_next;
    logic [2:0]       r_funct3;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_result;
    logic [CNT_W-1:0] r_cnt;
    logic             r_neg_q;
    logic             r_neg_r;

    logic             w_signed;
    logic             w_sa;
    logic             w_sb;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic             w_accept;
    logic             w_fast_zero;
    logic [WIDTH:0]   w_step_rem;
    logic [WIDTH-1:0] w_step_quo;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;
    logic [WIDTH-1:0] w_fix_val;

    assign w_signed = div_is_signed(bus.i_funct3);
    assign w_sa     = w_signed & bus.i_dividend[WIDTH-1];
    assign w_sb     = w_signed & bus.i_divisor[WIDTH-1];
    assign w_abs_a  = w_sa ? -bus.i_dividend : bus.i_dividend;
    assign w_abs_b  = w_sb ? -bus.i_divisor  : bus.i_divisor;
    assign w_accept = (r_state == DIV_IDLE) & bus.i_start & ~bus.i_flush;

`ifdef RV_DIV_FAST_ZERO_EN
    assign w_fast_zero = (bus.i_divisor == '0);
`else
    assign w_fast_zero = 1'b0;
`endif

    rv_div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_div (r_div),
        .o_rem (w_step_rem),
        .o_quo (w_step_quo)
    );

    // Divide by zero must keep the all-ones quotient, so only negate for a real divisor.
    assign w_q_fix   = (r_neg_q && (r_div != '0)) ? -r_quo : r_quo;
    assign w_r_fix   = r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
    assign w_fix_val = div_is_rem(r_funct3) ? w_r_fix : w_q_fix;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= DIV_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        bus.o_busy  = 1'b0;
        bus.o_valid = 1'b0;
        case (r_state)
            DIV_IDLE: begin
                bus.o_busy = bus.i_start;
                if (bus.i_start) begin
                    w_next = w_fast_zero ? DIV_DONE : DIV_CALC;
                end
            end
            DIV_CALC: begin
                bus.o_busy = 1'b1;
                if (r_cnt == '0) begin
                    w_next = DIV_FIX;
                end
            end
            DIV_FIX: begin
                bus.o_busy = 1'b1;
                w_next     = DIV_DONE;
            end
            DIV_DONE: begin
                bus.o_valid = 1'b1;
                if (!bus.i_stall) begin
                    w_next = DIV_IDLE;
                end
            end
            default: w_next = DIV_IDLE;
        endcase
        if (bus.i_flush) begin
            w_next = DIV_IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_funct3 <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_cnt    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else if (w_accept) begin
            r_funct3 <= bus.i_funct3;
            r_rem    <= '0;
            r_quo    <= w_abs_a;
            r_div    <= w_abs_b;
            r_cnt    <= CNT_W'(WIDTH - 1);
            r_neg_q  <= w_sa ^ w_sb;
            r_neg_r  <= w_sa;
            if (w_fast_zero) begin
                r_result <= div_is_rem(bus.i_funct3) ? bus.i_dividend : '1;
            end
        end else if (r_state == DIV_CALC) begin
            r_rem <= w_step_rem;
            r_quo <= w_step_quo;
            r_cnt <= r_cnt - 1'b1;
        end else if ((r_state == DIV_FIX) && !bus.i_flush) begin
            r_result <= w_fix_val;
        end
    end

    assign bus.o_result = r_result;
endmodule

// File: tb/tb_rv_div_seq.sv
// tb/tb_rv_div_seq.sv - randomized and directed checks of rv_div_seq against a cycle-level behavioural model
module tb_rv_div_seq;
    import rv_div_seq_pkg::*;

    localparam int LAT = 34;
`ifdef RV_DIV_FAST_ZERO_EN
    localparam int LAT_ZERO = 1;
`else
    localparam int LAT_ZERO = 34;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    rv_div_seq_if #(.WIDTH(32)) bus ();

    rv_div_seq #(.WIDTH(32)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        case (f3)
            DIV_F3_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            DIV_F3_REMU: return (b == 0) ? a : a % b;
            DIV_F3_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return sa / sb;
            end
            DIV_F3_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return sa % sb;
            end
            default: return 32'h0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: cycles left until DONE, whether DONE is being held, and the result register.
    int          m_left = 0;
    bit          m_done = 1'b0;
    bit          m_init = 1'b0;
    logic [31:0] m_exp  = '0;
    logic [31:0] m_res  = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_left = 0;
            m_done = 1'b0;
            m_res  = '0;
            m_init = 1'b1;
        end else if (bus.i_flush) begin
            m_left = 0;
            m_done = 1'b0;
        end else if (m_done) begin
            if (!bus.i_stall) m_done = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1'b1;
                m_res  = m_exp;
            end
        end else if (bus.i_start) begin
            m_exp  = ref_div(bus.i_funct3, bus.i_dividend, bus.i_divisor);
            m_left = (bus.i_divisor == 0) ? LAT_ZERO - 1 : LAT - 1;
            if (m_left == 0) begin
                m_done = 1'b1;
                m_res  = m_exp;
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            check("busy",   {31'b0, bus.o_busy},  {31'b0, (m_left > 0) || (!m_done && bus.i_start)});
            check("valid",  {31'b0, bus.o_valid}, {31'b0, m_done});
            check("result", bus.o_result, m_res);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat, input int stall_cycles);
        int lat;
        int nbusy;
        int nvalid;
        bus.i_funct3   = f3;
        bus.i_dividend = a;
        bus.i_divisor  = b;
        bus.i_stall    = (stall_cycles > 0);
        bus.i_start    = 1'b1;
        @(negedge clk);
        lat   = 0;
        nbusy = 0;
        while (!bus.o_valid && lat < 100) begin
            if (bus.o_busy) nbusy++;
            @(negedge clk);
            lat++;
        end
        check({name, "_lat"},  lat,   exp_lat);
        check({name, "_busy"}, nbusy, exp_lat);
        check({name, "_res"},  bus.o_result, exp);
        nvalid = 1;
        for (int k = 1; k <= stall_cycles; k++) begin
            cyc();
            if (k == stall_cycles) bus.i_stall = 1'b0;
            @(negedge clk);
            if (bus.o_valid && bus.o_result === exp) nvalid++;
        end
        check({name, "_hold"}, nvalid, stall_cycles + 1);
        cyc();
        bus.i_start = 1'b0;
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        int          kind;
        reset          = 1'b1;
        bus.i_flush    = 1'b0;
        bus.i_stall    = 1'b0;
        bus.i_start    = 1'b0;
        bus.i_funct3   = DIV_F3_DIVU;
        bus.i_dividend = '0;
        bus.i_divisor  = '0;
        repeat (2) cyc();
        reset = 1'b0;
        @(negedge clk);
        check("reset_valid",  {31'b0, bus.o_valid}, 32'h0);
        check("reset_result", bus.o_result, 32'h0);
        cyc();

        run_op("divu_100_7",  DIV_F3_DIVU, 32'd100, 32'd7, 32'd14, LAT, 0);
        run_op("remu_100_7",  DIV_F3_REMU, 32'd100, 32'd7, 32'd2,  LAT, 0);
        run_op("div_m7_2",    DIV_F3_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LAT, 0);
        run_op("rem_m7_2",    DIV_F3_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LAT, 0);
        run_op("div_ovf",     DIV_F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT, 0);
        run_op("rem_ovf",     DIV_F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, LAT, 0);
        run_op("divu_5_0",    DIV_F3_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, LAT_ZERO, 0);
        run_op("rem_5_0",     DIV_F3_REM,  32'd5, 32'd0, 32'd5, LAT_ZERO, 0);
        run_op("div_m7_0",    DIV_F3_DIV,  32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, LAT_ZERO, 0);

        // Abort mid-CALC, then start a fresh op in the very next cycle.
        bus.i_funct3   = DIV_F3_DIVU;
        bus.i_dividend = 32'd100;
        bus.i_divisor  = 32'd7;
        bus.i_start    = 1'b1;
        repeat (10) cyc();
        bus.i_flush = 1'b1;
        bus.i_start = 1'b0;
        cyc();
        bus.i_flush = 1'b0;
        run_op("flush_then_divu", DIV_F3_DIVU, 32'd9, 32'd3, 32'd3, LAT, 0);

        run_op("stall_divu", DIV_F3_DIVU, 32'd200, 32'd9, 32'd22, LAT, 3);

        // Flush and start together in IDLE: nothing may be latched.
        bus.i_funct3   = DIV_F3_DIVU;
        bus.i_dividend = 32'd50;
        bus.i_divisor  = 32'd5;
        bus.i_start    = 1'b1;
        bus.i_flush    = 1'b1;
        cyc();
        bus.i_start = 1'b0;
        bus.i_flush = 1'b0;
        @(negedge clk);
        check("flush_start_busy", {31'b0, bus.o_busy}, 32'h0);
        repeat (40) cyc();
        check("flush_start_res", bus.o_result, 32'd22);

        // Reset mid-CALC clears the result register.
        bus.i_start = 1'b1;
        repeat (15) cyc();
        reset       = 1'b1;
        bus.i_start = 1'b0;
        cyc();
        reset = 1'b0;
        @(negedge clk);
        check("rst_calc_result", bus.o_result, 32'h0);
        check("rst_calc_valid",  {31'b0, bus.o_valid}, 32'h0);
        cyc();

        for (int i = 0; i < 30; i++) begin
            f3   = 3'b100 | 3'($urandom_range(0, 3));
            kind = $urandom_range(0, 6);
            a    = $urandom;
            b    = $urandom;
            case (kind)
                1: b = 32'h0;
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 20); end
                4: b = 32'hFFFF_FFFF;
                5: b = $urandom_range(1, 255) | (b & 32'h8000_0000);
                default: ;
            endcase
            if ($urandom_range(0, 4) == 0) begin
                bus.i_funct3   = f3;
                bus.i_dividend = a;
                bus.i_divisor  = b;
                bus.i_start    = 1'b1;
                repeat ($urandom_range(1, 36)) cyc();
                bus.i_flush = 1'b1;
                bus.i_start = 1'b0;
                cyc();
                bus.i_flush = 1'b0;
            end else begin
                run_op("rand", f3, a, b, ref_div(f3, a, b), (b == 0) ? LAT_ZERO : LAT, $urandom_range(0, 3));
            end
        end

        repeat (5) cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
